// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding and width helpers for the PLL supervisor.
package pll_seq_pkg;

    typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, STABLE, ENABLE, RUN, FAULT} pll_state_e;

    // One bit of headroom over the longest interval the shared timer must count.
    function automatic int clog2_max(input int a, input int b, input int c, input int d);
        int m;
        m = a > b ? a : b;
        m = m > c ? m : c;
        m = m > d ? m : d;
        return $clog2(m) + 1;
    endfunction

    function automatic int width_of(input int v);
        return v < 3 ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/pll_ch_gate.sv
// pll_ch_gate: one output channel's clock enable plus its delayed domain-reset release.
module pll_ch_gate
    import pll_seq_pkg::*;
#(
    parameter int STAGGER_CYCLES = 16
) (
    input  logic ref_clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic force_off_i,
    output logic clk_en_o,
    output logic ch_rst_n_o
);
    localparam int CW = width_of(STAGGER_CYCLES + 1);
    localparam logic [CW-1:0] C_LOAD = CW'(STAGGER_CYCLES);

    logic          clk_en_q, clk_en_d, ch_rst_n_q, ch_rst_n_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The countdown reloads only on a rising enable, so a re-request restarts it in full.
    always_comb begin
        clk_en_d   = en_i && !force_off_i;
        ch_rst_n_d = clk_en_d && clk_en_q && (ch_rst_n_q || cnt_q == CW'(1));
        cnt_d      = !clk_en_d ? '0 : !clk_en_q ? C_LOAD : (cnt_q != '0) ? cnt_q - 1'b1 : '0;
    end

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_en_q   <= 1'b0;
            ch_rst_n_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            clk_en_q   <= clk_en_d;
            ch_rst_n_q <= ch_rst_n_d;
            cnt_q      <= cnt_d;
        end
    end

    assign clk_en_o   = clk_en_q;
    assign ch_rst_n_o = ch_rst_n_q;

endmodule

// File: rtl/pll_seq.sv
// pll_seq: PLL reset/lock supervisor with staggered enable of N gated output clocks.
module pll_seq
    import pll_seq_pkg::*;
#(
    parameter int N_CLK               = 4,
    parameter int PLL_RST_CYCLES      = 32,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int STAGGER_CYCLES      = 16,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                                   ref_clk,
    input  logic                                   rst_n,
    input  logic                                   pll_lock,
    input  logic [N_CLK-1:0]                       clk_req,
    input  logic                                   clear_fault,
    output logic                                   pll_reset,
    output logic [N_CLK-1:0]                       clk_en,
    output logic [N_CLK-1:0]                       ch_rst_n,
    output logic                                   ready,
    output logic                                   fault,
    output logic                                   lock_lost,
    output logic [width_of(MAX_RETRIES+1)-1:0]     retry_cnt
);
    localparam int TW = clog2_max(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES, STAGGER_CYCLES);
    localparam int IW = width_of(N_CLK);
    localparam int RW = width_of(MAX_RETRIES + 1);
    localparam logic [TW-1:0] T_RST = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] T_TO  = TW'(LOCK_TIMEOUT_CYCLES - 1);
    // The WAIT_LOCK cycle that first sees lock counts toward the stable window.
    localparam logic [TW-1:0] T_STB = TW'(LOCK_STABLE_CYCLES > 1 ? LOCK_STABLE_CYCLES - 2 : 0);
    localparam logic [TW-1:0] T_STG = TW'(STAGGER_CYCLES - 1);
    localparam logic [IW-1:0] I_LAST = IW'(N_CLK - 1);
    localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRIES);

    pll_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [1:0]    sync_q;
    logic          pll_reset_q, ready_q, fault_q, lock_lost_q, lock_lost_d;
    logic          lock_s;
    logic [N_CLK-1:0] open;

    assign lock_s = sync_q[1];

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + 1'b1;
        idx_d       = idx_q;
        retry_d     = retry_q;
        lock_lost_d = 1'b0;
        case (state_q)
            PLL_RST:   if (timer_q == T_RST) state_d = WAIT_LOCK;
            WAIT_LOCK: begin
                if (lock_s) state_d = STABLE;
                else if (timer_q == T_TO) begin
                    state_d = (retry_q == R_MAX) ? FAULT : PLL_RST;
                    retry_d = (retry_q == R_MAX) ? retry_q : retry_q + 1'b1;
                end
            end
            STABLE: begin
                if (!lock_s) state_d = WAIT_LOCK;
                else if (timer_q == T_STB) begin
                    state_d = ENABLE;
                    idx_d   = '0;
                end
            end
            ENABLE, RUN: begin
                if (!lock_s) begin
                    state_d     = WAIT_LOCK;
                    lock_lost_d = 1'b1;
                end else if (state_q == ENABLE && timer_q == T_STG) begin
                    if (idx_q == I_LAST) begin
                        state_d = RUN;
                        retry_d = '0;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        timer_d = '0;
                    end
                end
            end
            FAULT: begin
                if (clear_fault) begin
                    state_d = PLL_RST;
                    retry_d = '0;
                end
            end
            default: state_d = PLL_RST;
        endcase
        if (state_d != state_q) timer_d = '0;
        for (int i = 0; i < N_CLK; i++)
            open[i] = (state_d == RUN) || (state_d == ENABLE && i <= int'(idx_d));
    end

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PLL_RST;
            timer_q     <= '0;
            idx_q       <= '0;
            retry_q     <= '0;
            sync_q      <= '0;
            pll_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            idx_q       <= idx_d;
            retry_q     <= retry_d;
            sync_q      <= {sync_q[0], pll_lock};
            pll_reset_q <= (state_d == PLL_RST) || (state_d == FAULT);
            ready_q     <= state_d == RUN;
            fault_q     <= state_d == FAULT;
            lock_lost_q <= lock_lost_d;
        end
    end

    for (genvar i = 0; i < N_CLK; i++) begin : g_ch
        pll_ch_gate #(.STAGGER_CYCLES(STAGGER_CYCLES)) u_gate (
            .ref_clk     (ref_clk),
            .rst_n       (rst_n),
            .en_i        (clk_req[i] && open[i]),
            .force_off_i (!open[i]),
            .clk_en_o    (clk_en[i]),
            .ch_rst_n_o  (ch_rst_n[i])
        );
    end

    assign pll_reset = pll_reset_q;
    assign ready     = ready_q;
    assign fault     = fault_q;
    assign lock_lost = lock_lost_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_seq.sv
// tb_pll_seq: directed stimulus with a change-event scoreboard for pll_seq.
module tb_pll_seq;

    typedef struct {
        int         cyc;
        logic [9:0] v;
        string      nm;
    } exp_t;

    logic       ref_clk = 1'b0;
    logic       rst_n, pll_lock, clear_fault, done;
    logic [1:0] clk_req;
    logic       pll_reset, ready, fault, lock_lost;
    logic [1:0] clk_en, ch_rst_n, retry_cnt;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    exp_t       exp_q[$];

    pll_seq #(
        .N_CLK(2), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT_CYCLES(64),
        .LOCK_STABLE_CYCLES(8), .STAGGER_CYCLES(4), .MAX_RETRIES(2)
    ) dut (
        .ref_clk(ref_clk), .rst_n(rst_n), .pll_lock(pll_lock), .clk_req(clk_req),
        .clear_fault(clear_fault), .pll_reset(pll_reset), .clk_en(clk_en),
        .ch_rst_n(ch_rst_n), .ready(ready), .fault(fault), .lock_lost(lock_lost),
        .retry_cnt(retry_cnt)
    );

    always #5 ref_clk = ~ref_clk;
    always @(posedge ref_clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic pr, input logic [1:0] en, input logic [1:0] rn,
                        input logic rdy, input logic flt, input logic ll, input logic [1:0] rc,
                        input string nm);
        exp_t e;
        e.cyc = c;
        e.v   = {pr, en, rn, rdy, flt, ll, rc};
        e.nm  = nm;
        exp_q.push_back(e);
    endtask

    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge ref_clk);
            #1;
        end
    endtask

    // Every observed change of the output vector must match the next expected change, value and cycle.
    initial begin : monitor
        logic [9:0] prev, cur;
        exp_t e;
        prev = 'x;
        while (!done) begin
            @(negedge ref_clk or negedge rst_n);
            #1;
            cur = {pll_reset, clk_en, ch_rst_n, ready, fault, lock_lost, retry_cnt};
            if (cur !== prev) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: cyc %0d got %b, want no change", cyc, cur);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.v !== cur) begin
                        n_fail++;
                        $display("FAIL %s: got cyc %0d %b, want cyc %0d %b", e.nm, cyc, cur, e.cyc, e.v);
                    end
                end
                prev = cur;
            end
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events: got %0d unseen, want 0 (next %s at cyc %0d)",
                     exp_q.size(), exp_q[0].nm, exp_q[0].cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : stim
        done = 1'b0; rst_n = 1'b1; pll_lock = 1'b0; clk_req = 2'b11; clear_fault = 1'b0;
        push(0, 1, 2'b00, 2'b00, 0, 0, 0, 2'd0, "reset_values");
        #2 rst_n = 1'b0;
        at(3);
        push(7, 0, 2'b00, 2'b00, 0, 0, 0, 2'd0, "pll_reset_fall");
        rst_n = 1'b1;
        // Clean bring-up
        at(17);
        pll_lock = 1'b1;
        push(27, 0, 2'b01, 2'b00, 0, 0, 0, 2'd0, "clk_en0_rise");
        push(31, 0, 2'b11, 2'b01, 0, 0, 0, 2'd0, "clk_en1_ch_rst0");
        push(35, 0, 2'b11, 2'b11, 1, 0, 0, 2'd0, "ready_ch_rst1");
        // Channel request in RUN
        at(40);
        clk_req = 2'b01;
        push(41, 0, 2'b01, 2'b01, 1, 0, 0, 2'd0, "req1_off");
        at(45);
        clk_req = 2'b11;
        push(46, 0, 2'b11, 2'b01, 1, 0, 0, 2'd0, "req1_on");
        push(50, 0, 2'b11, 2'b11, 1, 0, 0, 2'd0, "req1_ch_rst_rise");
        // Lock loss in RUN, then full re-sequence
        at(55);
        pll_lock = 1'b0;
        push(58, 0, 2'b00, 2'b00, 0, 0, 1, 2'd0, "lock_lost_pulse");
        push(59, 0, 2'b00, 2'b00, 0, 0, 0, 2'd0, "lock_lost_end");
        at(62);
        pll_lock = 1'b1;
        push(72, 0, 2'b01, 2'b00, 0, 0, 0, 2'd0, "reseq_en0");
        push(76, 0, 2'b11, 2'b01, 0, 0, 0, 2'd0, "reseq_en1");
        push(80, 0, 2'b11, 2'b11, 1, 0, 0, 2'd0, "reseq_ready");
        // Lock glitch during STABLE restarts the stable count
        at(85);
        pll_lock = 1'b0;
        push(88, 0, 2'b00, 2'b00, 0, 0, 1, 2'd0, "lock_lost2_pulse");
        push(89, 0, 2'b00, 2'b00, 0, 0, 0, 2'd0, "lock_lost2_end");
        at(92);
        pll_lock = 1'b1;
        at(98);
        pll_lock = 1'b0;
        at(99);
        pll_lock = 1'b1;
        push(109, 0, 2'b01, 2'b00, 0, 0, 0, 2'd0, "glitch_en0");
        push(113, 0, 2'b11, 2'b01, 0, 0, 0, 2'd0, "glitch_en1");
        push(117, 0, 2'b11, 2'b11, 1, 0, 0, 2'd0, "glitch_ready");
        // Lock never returns: two retries then FAULT
        at(120);
        pll_lock = 1'b0;
        push(123, 0, 2'b00, 2'b00, 0, 0, 1, 2'd0, "lock_lost3_pulse");
        push(124, 0, 2'b00, 2'b00, 0, 0, 0, 2'd0, "lock_lost3_end");
        push(187, 1, 2'b00, 2'b00, 0, 0, 0, 2'd1, "timeout1");
        push(191, 0, 2'b00, 2'b00, 0, 0, 0, 2'd1, "retry1_release");
        push(255, 1, 2'b00, 2'b00, 0, 0, 0, 2'd2, "timeout2");
        push(259, 0, 2'b00, 2'b00, 0, 0, 0, 2'd2, "retry2_release");
        push(323, 1, 2'b00, 2'b00, 0, 1, 0, 2'd2, "fault_entry");
        at(330);
        clear_fault = 1'b1;
        push(331, 1, 2'b00, 2'b00, 0, 0, 0, 2'd0, "clear_fault");
        at(331);
        clear_fault = 1'b0;
        push(335, 0, 2'b00, 2'b00, 0, 0, 0, 2'd0, "post_fault_release");
        // clear_fault outside FAULT must not disturb anything
        at(340);
        clear_fault = 1'b1;
        at(341);
        clear_fault = 1'b0;
        // Async reset mid-ENABLE
        at(345);
        pll_lock = 1'b1;
        push(355, 0, 2'b01, 2'b00, 0, 0, 0, 2'd0, "enable_before_reset");
        at(357);
        pll_lock = 1'b0;
        push(357, 1, 2'b00, 2'b00, 0, 0, 0, 2'd0, "async_reset");
        #1 rst_n = 1'b0;
        at(359);
        rst_n = 1'b1;
        push(363, 0, 2'b00, 2'b00, 0, 0, 0, 2'd0, "reset_release_fall");
        at(370);
        done = 1'b1;
    end

endmodule
